led_chaser: RTL and testbench
=============================

# led_chaser

Parametrised LED sequencer for the board LED bank. It replaces the fixed count-to-one-hot LED decoder with a self-timed block: an internal prescaler steps a position register, and the position is shown as a running dot (up, down, bounce) or as a fill bar. The block sits between the board clock and the LED pins and runs on its own, with no external counter.

## Interface
- N_LED, 6, number of LEDs driven; legal range 2..32.
- DIV, 25_000_000, clock cycles per step; legal range ≥1. Benches use small values.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  run enable; when low, the prescaler and position hold.
- mode  input  2  pattern select: 00 chase up, 01 chase down, 10 bounce, 11 fill bar.
- led_light  output  N_LED  LED drive, 1 = lit; bit 0 is the lowest LED.
- pos  output  $clog2(N_LED)  current position, 0..N_LED-1.
- wrap  output  1  one-cycle pulse marking the end of a pattern pass.

## Operation
- Registers:
  - cnt, prescaler, range 0..DIV-1.
  - pos.
  - dir, 0 = up, 1 = down.
  - wrap.
- Tick: internal, and true when en=1 and cnt==DIV-1.
  - On a tick cnt returns to 0. Otherwise, when en=1, cnt increments.
  - When en=0, cnt holds.
  - With DIV=1, every enabled cycle is a tick.
- pos and dir change only on a tick. The rules per mode:
  - 00 and 11: pos = (pos==N_LED-1) ? 0 : pos+1.
  - 01: pos = (pos==0) ? N_LED-1 : pos-1.
  - 10 with dir=0: if pos==N_LED-1 then dir←1 and pos←N_LED-2, else pos+1.
  - 10 with dir=1: if pos==0 then dir←0 and pos←1, else pos-1.
- In any mode other than 10, dir is cleared to 0 on every clock. Entering bounce therefore always starts upward.
- A mode change never alters pos or cnt.
- wrap is registered. It is 1 for exactly the one cycle after a tick edge that causes any of these:
  - In 00 or 11, pos goes N_LED-1→0.
  - In 01, pos goes 0→N_LED-1.
  - In 10, dir reverses, at either end.
- wrap is 0 on all other cycles.
- led_light is combinational from pos and mode:
  - Modes 00, 01 and 10: one-hot, led_light[i] = (i==pos).
  - Mode 11: thermometer, led_light[i] = (i<=pos).
  - A mode change takes effect on led_light in the same cycle.
- pos always stays within 0..N_LED-1. Out-of-range values are unreachable.

## Timing
- Reset (rst=1 at an edge) sets cnt=0, pos=0, dir=0 and wrap=0.
  - led_light = 1 in every mode, i.e. bit 0 only.
  - Reset has priority over en and any tick.
  - Reset asserted mid-pattern drops to this state at the next edge.
- After reset deasserts with en=1, the first pos change happens DIV rising edges later. Subsequent changes follow every DIV edges.
- Deasserting en freezes the remaining phase. Reasserting en resumes the count, so the interval spanning the pause totals DIV enabled cycles.
- pos, dir and wrap update on the same edge. led_light follows pos with no extra latency.
- Chase period is N_LED ticks. Bounce period is 2·(N_LED-1) ticks.

## Test plan
Benches use N_LED=6 and DIV=3 unless stated.
- Reset then mode=00, en=1 → led_light sequence 000001, 000010, …, 100000, 000001; each step lasts 3 cycles; wrap pulses one cycle as pos goes 5→0.
- mode=01 from reset → pos sequence 0, 5, 4, 3, 2, 1, 0; wrap pulses on 0→5 and on no other step.
- mode=10 from reset → pos sequence 0, 1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1; wrap pulses at the 5→4 and 0→1 steps; each pos value, including the ends, is held for one tick.
- mode=11 → led_light sequence 000001, 000011, 000111, …, 111111, 000001; switching mode to 00 while pos=3 gives led_light=001000 in the same cycle, with pos unchanged.
- en dropped for 10 cycles one cycle after a step → pos and led_light hold; the next step comes 2 enabled cycles after en returns.
- rst pulsed while mode=10 with dir=1 and pos=3 → next cycle pos=0, led_light=000001, wrap=0; the first subsequent step goes to pos=1 (upward). Repeat with N_LED=2 and DIV=1 in bounce mode → pos toggles 0, 1, 0 every cycle and wrap is high every cycle after the first step.

Source files
------------

// File: rtl/led_chaser.sv
// Self-timed LED sequencer: prescaled position stepping
// shown as a running dot (up/down/bounce) or a fill bar.
module led_chaser #(
  parameter int N_LED = 6,
  parameter int DIV   = 25_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [1:0]               mode,
  output logic [N_LED-1:0]         led_light,
  output logic [$clog2(N_LED)-1:0] pos,
  output logic                     wrap
);

  localparam int PW = $clog2(N_LED);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] TOP  = PW'(N_LED - 1);
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

  logic [CW-1:0] cnt;
  dir_t          dir;
  logic          tick;

  assign tick = en && (cnt == CMAX);

  // Prescaler, position, bounce direction and end-of-pass pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      pos  <= '0;
      dir  <= UP;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (mode != 2'b10)
        dir <= UP;
      if (en)
        cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        case (mode)
          2'b01: begin
            if (pos == '0) begin
              pos  <= TOP;
              wrap <= 1'b1;
            end else begin
              pos <= pos - 1'b1;
            end
          end
          2'b10: begin
            if (dir == UP) begin
              if (pos == TOP) begin
                dir  <= DOWN;
                pos  <= TOP - 1'b1;
                wrap <= 1'b1;
              end else begin
                pos <= pos + 1'b1;
              end
            end else begin
              if (pos == '0) begin
                dir  <= UP;
                pos  <= PW'(1);
                wrap <= 1'b1;
              end else begin
                pos <= pos - 1'b1;
              end
            end
          end
          default: begin
            if (pos == TOP) begin
              pos  <= '0;
              wrap <= 1'b1;
            end else begin
              pos <= pos + 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Dot or thermometer view of the current position
  always_comb begin
    led_light = '0;
    for (int i = 0; i < N_LED; i++) begin
      if (mode == 2'b11)
        led_light[i] = (i <= int'(pos));
      else
        led_light[i] = (i == int'(pos));
    end
  end

endmodule

// File: tb/tb_led_chaser.sv
// Bench for led_chaser: directed scenarios plus random
// traffic against a phase-unfolded reference model.
module tb_led_chaser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       en2 = 1'b1;
  logic [1:0] mode2 = 2'b10;

  logic [5:0] led1;
  logic [2:0] pos1;
  logic       wrap1;
  logic [1:0] led2;
  logic [0:0] pos2;
  logic       wrap2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  led_chaser #(.N_LED(6), .DIV(3)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .led_light(led1), .pos(pos1), .wrap(wrap1)
  );

  led_chaser #(.N_LED(2), .DIV(1)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .mode(mode2),
    .led_light(led2), .pos(pos2), .wrap(wrap2)
  );

  // Bounce is modelled as an unfolded phase 0..2(N-1):
  // pos = phase on the way up, 2(N-1)-phase on the way down.
  typedef struct {
    int cnt;
    int pos;
    int phase;
    bit wrap;
  } model_t;

  model_t m1, m2;

  function automatic logic [31:0] led_of(int p, logic [1:0] md);
    logic [31:0] one;
    one = 32'd1;
    if (md == 2'b11)
      return (one << (p + 1)) - 1;
    return one << p;
  endfunction

  task automatic mstep(inout model_t m, input int n, input int d,
                       input logic r, input logic e,
                       input logic [1:0] md);
    bit tk;
    if (r) begin
      m.cnt = 0; m.pos = 0; m.phase = 0; m.wrap = 0;
    end else begin
      m.wrap = 0;
      tk = e && (m.cnt == d - 1);
      if (e) m.cnt = tk ? 0 : m.cnt + 1;
      if (md == 2'b10) begin
        if (tk) begin
          if (m.phase == 2 * (n - 1)) begin
            m.phase = 1; m.wrap = 1;
          end else if (m.phase == n - 1) begin
            m.phase = n; m.wrap = 1;
          end else begin
            m.phase++;
          end
        end
        m.pos = (m.phase < n) ? m.phase : 2 * (n - 1) - m.phase;
      end else begin
        if (tk) begin
          if (md == 2'b01) begin
            m.wrap = (m.pos == 0);
            m.pos = (m.pos + n - 1) % n;
          end else begin
            m.wrap = (m.pos == n - 1);
            m.pos = (m.pos + 1) % n;
          end
        end
        m.phase = m.pos;
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("pos1", 32'(pos1), 32'(m1.pos));
    chk("led1", 32'(led1), led_of(m1.pos, mode));
    chk("wrap1", 32'(wrap1), 32'(m1.wrap));
    chk("pos2", 32'(pos2), 32'(m2.pos));
    chk("led2", 32'(led2), led_of(m2.pos, mode2));
    chk("wrap2", 32'(wrap2), 32'(m2.wrap));
  endtask

  task automatic step();
    @(posedge clk);
    mstep(m1, 6, 3, rst, en, mode);
    mstep(m2, 2, 1, rst, en2, mode2);
    #1;
    check_all();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    bit found;
    int wrap_cnt;
    m1 = '{0, 0, 0, 0};
    m2 = '{0, 0, 0, 0};

    // Reset state
    rst = 1'b1;
    run(2);
    chk("rst_led", 32'(led1), 32'h01);
    chk("rst_pos", 32'(pos1), 32'd0);
    chk("rst_wrap", 32'(wrap1), 32'd0);

    // Chase up: 6 steps of 3 cycles, one wrap per pass
    rst = 1'b0; en = 1'b1; mode = 2'b00;
    wrap_cnt = 0;
    for (int i = 0; i < 18; i++) begin
      step();
      wrap_cnt += int'(wrap1);
    end
    chk("up_wraps", 32'(wrap_cnt), 32'd1);
    chk("up_led_end", 32'(led1), 32'h01);
    run(20);

    // Chase down
    do_reset();
    mode = 2'b01;
    run(25);

    // Bounce from reset
    do_reset();
    mode = 2'b10;
    wrap_cnt = 0;
    for (int i = 0; i < 33; i++) begin
      step();
      wrap_cnt += int'(wrap1);
    end
    chk("bounce_wraps", 32'(wrap_cnt), 32'd2);
    chk("bounce_pos", 32'(pos1), 32'd1);
    run(10);

    // Fill bar, then switch to chase at pos 3
    do_reset();
    mode = 2'b11;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (pos1 == 3'd3) found = 1;
    end
    chk("fill_reach3", 32'(found), 32'd1);
    chk("fill_led3", 32'(led1), 32'h0f);
    mode = 2'b00;
    #1;
    chk("switch_led", 32'(led1), 32'h08);
    check_all();
    run(6);

    // Pause: en low for 10 cycles one cycle after a step
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (m1.cnt == 0) found = 1;
    end
    chk("pause_sync", 32'(found), 32'd1);
    step();
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(8);

    // Reset while bouncing downward at pos 3
    do_reset();
    mode = 2'b10;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (m1.phase > 5 && pos1 == 3'd3) found = 1;
    end
    chk("dir_down_pos3", 32'(found), 32'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_pos", 32'(pos1), 32'd0);
    chk("mid_rst_led", 32'(led1), 32'h01);
    chk("mid_rst_wrap", 32'(wrap1), 32'd0);
    rst = 1'b0;
    run(4);
    chk("post_rst_up", 32'(pos1), 32'd1);
    chk("n2_wrap", 32'(wrap2), 32'd1);
    run(6);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 85) en = 1'b1;
      else en = 1'b0;
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 9) == 0) en2 = ~en2;
      if ($urandom_range(0, 29) == 0) mode2 = 2'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) begin
        #2;
        #1;
        chk("comb_led1", 32'(led1), led_of(m1.pos, mode));
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
